// File: rtl/data_compress_if.sv
// Byte-stream handshake between an uncompressed source and the compressor.
interface data_compress_if #(
  parameter int unsigned DW = 8
);
  logic [DW-1:0] din;
  logic          den;
  logic          hold;
  logic [DW-1:0] dout;
  logic          vldo;
  logic          rdy;

  // Source side: drives bytes, observes the compressed stream.
  modport master (
    output din, den, hold,
    input  dout, vldo, rdy
  );

  // Compressor side.
  modport slave (
    input  din, den, hold,
    output dout, vldo, rdy
  );
endinterface

// File: rtl/data_compress.sv
// Byte-stream compressor: forwards accepted bytes, or repeats the previous output when the
// source marks a byte with hold. At most MAX_REPEAT repeats in a row before a forced literal.
module data_compress #(
  parameter int unsigned DW         = 8,
  parameter int unsigned MAX_REPEAT = 4  // legal 1..255
) (
  input logic            clk,
  input logic            rst_n,
  data_compress_if.slave bus
);

  localparam logic [7:0] MaxRep = 8'(MAX_REPEAT);

  logic [DW-1:0] dout_q, dout_d;
  logic [DW-1:0] last_q, last_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          vldo_q, vldo_d;
  logic          rdy_q;
  logic          have_last_q, have_last_d;
  logic          accept;
  logic          literal;

  assign accept = bus.den & rdy_q;
  // A held byte still goes out literally before anything was emitted or once the run is full.
  assign literal = ~bus.hold | ~have_last_q | (cnt_q == MaxRep);

  // Next-state selection for the output byte, last byte and repeat run length.
  always_comb begin
    dout_d      = dout_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    have_last_d = have_last_q;
    vldo_d      = 1'b0;
    if (accept) begin
      vldo_d      = 1'b1;
      have_last_d = 1'b1;
      if (literal) begin
        dout_d = bus.din;
        last_d = bus.din;
        cnt_d  = 8'd0;
      end else begin
        dout_d = last_q;
        cnt_d  = cnt_q + 8'd1;
      end
    end
  end

  // State registers; rdy rises on the first edge out of reset and never drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q      <= '0;
      last_q      <= '0;
      cnt_q       <= 8'd0;
      vldo_q      <= 1'b0;
      rdy_q       <= 1'b0;
      have_last_q <= 1'b0;
    end else begin
      dout_q      <= dout_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      vldo_q      <= vldo_d;
      rdy_q       <= 1'b1;
      have_last_q <= have_last_d;
    end
  end

  assign bus.dout = dout_q;
  assign bus.vldo = vldo_q;
  assign bus.rdy  = rdy_q;

endmodule

// File: tb/tb_data_compress.sv
// Bench for data_compress: directed test-plan sequences with literal expectations, then
// randomized traffic, all checked each cycle against a history-based reference model.
module tb_data_compress;

  localparam int unsigned DW     = 8;
  localparam int unsigned MAXREP = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic chk_en = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  data_compress_if #(.DW(DW)) bus ();

  data_compress #(.DW(DW), .MAX_REPEAT(MAXREP)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model: every emitted byte since reset, and whether it was a substitution.
  logic [DW-1:0] emit_q[$];
  bit            subst_q[$];
  logic [DW-1:0] m_dout;
  logic          m_vldo;
  logic          m_rdy;

  function automatic int trailing_subst();
    int n = 0;
    for (int i = subst_q.size() - 1; i >= 0; i--) begin
      if (!subst_q[i]) break;
      n++;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      emit_q.delete();
      subst_q.delete();
      m_dout <= '0;
      m_vldo <= 1'b0;
      m_rdy  <= 1'b0;
    end else begin
      m_rdy  <= 1'b1;
      m_vldo <= m_rdy && bus.den;
      if (m_rdy && bus.den) begin
        if (bus.hold && emit_q.size() != 0 && trailing_subst() < int'(MAXREP)) begin
          m_dout <= emit_q[$];
          emit_q.push_back(emit_q[$]);
          subst_q.push_back(1'b1);
        end else begin
          m_dout <= bus.din;
          emit_q.push_back(bus.din);
          subst_q.push_back(1'b0);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_dout", 32'(bus.dout), 32'(m_dout));
      check("model_vldo", 32'(bus.vldo), 32'(m_vldo));
      check("model_rdy", 32'(bus.rdy), 32'(m_rdy));
    end
  end

  task automatic reset_dut();
    bus.den = 1'b0;
    rst_n   = 1'b0;
    #1;
    check("rst_dout", 32'(bus.dout), 32'h0);
    check("rst_vldo", 32'(bus.vldo), 32'h0);
    check("rst_rdy", 32'(bus.rdy), 32'h0);
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  // Called at posedge+2; returns at the following posedge+2.
  task automatic send(input logic [7:0] d, input logic h, input logic [7:0] exp);
    bus.din  = d;
    bus.hold = h;
    bus.den  = 1'b1;
    @(posedge clk);
    #1;
    check("lit_dout", 32'(bus.dout), 32'(exp));
    check("lit_vldo", 32'(bus.vldo), 32'h1);
    #1;
  endtask

  task automatic idle(input int n, input logic [7:0] exp_dout);
    bus.den = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check("idle_vldo", 32'(bus.vldo), 32'h0);
      check("idle_rdy", 32'(bus.rdy), 32'h1);
      check("idle_dout", 32'(bus.dout), 32'(exp_dout));
      #1;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.din  = '0;
    bus.den  = 1'b0;
    bus.hold = 1'b0;
    #1;
    chk_en = 1'b1;
    // Reset then idle
    reset_dut();
    idle(3, 8'h00);
    // Basic stream
    send(8'h3F, 1'b0, 8'h3F);
    send(8'h0F, 1'b0, 8'h0F);
    send(8'h2F, 1'b1, 8'h0F);
    send(8'h8F, 1'b0, 8'h8F);
    idle(1, 8'h8F);
    // First-byte hold after reset
    reset_dut();
    idle(1, 8'h00);
    send(8'h55, 1'b1, 8'h55);
    send(8'hAA, 1'b1, 8'h55);
    // Repeat bound
    send(8'h11, 1'b0, 8'h11);
    send(8'h21, 1'b1, 8'h11);
    send(8'h22, 1'b1, 8'h11);
    send(8'h23, 1'b1, 8'h11);
    send(8'h24, 1'b1, 8'h11);
    send(8'h25, 1'b1, 8'h25);
    send(8'h26, 1'b1, 8'h25);
    // Gapped input: idle cycles do not break or extend a run
    send(8'h3F, 1'b0, 8'h3F);
    idle(2, 8'h3F);
    send(8'h9C, 1'b1, 8'h3F);
    // Mid-stream reset
    bus.din  = 8'h42;
    bus.hold = 1'b0;
    bus.den  = 1'b1;
    @(posedge clk);
    #1;
    check("mid_vldo_pre", 32'(bus.vldo), 32'h1);
    reset_dut();
    idle(1, 8'h00);
    send(8'h77, 1'b1, 8'h77);
    idle(1, 8'h77);
    // Randomized traffic, hold-heavy to exercise the repeat bound
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(299) == 0) begin
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      bus.den  = ($urandom_range(3) != 0);
      bus.hold = ($urandom_range(9) < 7);
      bus.din  = 8'($urandom);
      @(posedge clk);
      #2;
    end
    bus.den = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
